// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator front-panel controller.
//   - FSM state encoding used by calc_ctrl.
//   - op_sel bit ordering {R,L,C}, also consumed by the datapath decoder.
//   - Button index map for the debounced button vectors inside calc_ctrl.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // op_sel bit positions; the decoder relies on this ordering.
  localparam int unsigned OP_W     = 3;
  localparam int unsigned OP_BIT_C = 0;
  localparam int unsigned OP_BIT_L = 1;
  localparam int unsigned OP_BIT_R = 2;

  // Index of each button in the internal raw/level/press vectors.
  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned BTN_C   = 0;
  localparam int unsigned BTN_L   = 1;
  localparam int unsigned BTN_R   = 2;
  localparam int unsigned BTN_U   = 3;
  localparam int unsigned BTN_D   = 4;

  function automatic logic [OP_W-1:0] op_code(input logic r, input logic l, input logic c);
    logic [OP_W-1:0] code;
    code           = '0;
    code[OP_BIT_R] = r;
    code[OP_BIT_L] = l;
    code[OP_BIT_C] = c;
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   clk      in   system clock
//   rst_n    in   async active-low reset
//   raw_i    in   raw button, asynchronous to clk
//   level_o  out  debounced level
//   press_o  out  one-cycle pulse on a debounced rising edge
// A button already held when reset is released is not reported as a press:
// press pulses are only armed once the synchronised input has been seen low.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [DB_W-1:0] CNT_TC = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [1:0]      fill_q;
  logic            armed_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic            press_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw_i};
      // fill_q[1] marks that sync_q[1] now holds a real sample, not the reset value.
      fill_q       <= {fill_q[0], 1'b1};
      if (fill_q[1] && !sync_q[1]) begin
        armed_q <= 1'b1;
      end
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q & armed_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: front-panel sequencer for the calculator datapath.
//   clk, rst_n                    system clock, async active-low reset
//   btnc/btnl/btnr                raw operation-select buttons
//   btnu                          raw clear request
//   btnd                          raw execute request
//   op_sel[2:0]                   latched {R,L,C} selection
//   op_valid                      selection latched, awaiting execute
//   acc_load                      one-cycle accumulator load strobe
//   acc_clear                     one-cycle accumulator clear strobe
//   busy                          execute issued, waiting for btnd release
//
// state  | meaning
// IDLE   | nothing pending; btnd re-runs the last op_sel
// SELECT | selection latched, waiting for btnd
// EXEC   | acc_load strobe cycle
// HOLD   | waiting for debounced btnd low; presses ignored
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btnc,
  input  logic            btnl,
  input  logic            btnr,
  input  logic            btnu,
  input  logic            btnd,
  output logic [OP_W-1:0] op_sel,
  output logic            op_valid,
  output logic            acc_load,
  output logic            acc_clear,
  output logic            busy
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] prs;

  assign raw[BTN_C] = btnc;
  assign raw[BTN_L] = btnl;
  assign raw[BTN_R] = btnr;
  assign raw[BTN_U] = btnu;
  assign raw[BTN_D] = btnd;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw[g]),
      .level_o(lvl[g]),
      .press_o(prs[g])
    );
  end

  // The clear button acts on its press pulse only.
  logic unused_lvl_u;
  assign unused_lvl_u = lvl[BTN_U];

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_sel_q, op_sel_d;
  logic            clear_q, clear_d;
  logic            op_press;

  assign op_press = prs[BTN_C] | prs[BTN_L] | prs[BTN_R];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_sel_q <= '0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      clear_q  <= clear_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    clear_d  = 1'b0;
    if (prs[BTN_U]) begin
      // Clear wins over everything; a load already in EXEC has been issued.
      state_d  = ST_IDLE;
      op_sel_d = '0;
      clear_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_SELECT: begin
          if (prs[BTN_D]) begin
            state_d = ST_EXEC;
          end else if (op_press) begin
            state_d  = ST_SELECT;
            // Latch all current levels so simultaneous presses combine.
            op_sel_d = op_code(lvl[BTN_R], lvl[BTN_L], lvl[BTN_C]);
          end
        end
        ST_EXEC: state_d = ST_HOLD;
        ST_HOLD: begin
          if (!lvl[BTN_D]) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_valid  = (state_q == ST_SELECT);
    acc_load  = (state_q == ST_EXEC);
    busy      = (state_q == ST_EXEC) || (state_q == ST_HOLD);
    acc_clear = clear_q;
    op_sel    = op_sel_q;
  end

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnc, btnl, btnr, btnu, btnd;
  logic [2:0] op_sel;
  logic       op_valid, acc_load, acc_clear, busy;

  int total = 0;
  int bad   = 0;
  int n_load  = 0;
  int n_clear = 0;
  int n_both  = 0;

  always #5 clk = ~clk;

  calc_ctrl #(.DB_CYCLES(4), .DB_W(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btnc     (btnc),
    .btnl     (btnl),
    .btnr     (btnr),
    .btnu     (btnu),
    .btnd     (btnd),
    .op_sel   (op_sel),
    .op_valid (op_valid),
    .acc_load (acc_load),
    .acc_clear(acc_clear),
    .busy     (busy)
  );

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (acc_load === 1'b1)  n_load++;
    if (acc_clear === 1'b1) n_clear++;
    if (acc_load === 1'b1 && acc_clear === 1'b1) n_both++;
  end

  typedef struct {
    logic [4:0] btn;     // {u,d,r,l,c}
    int         hold;
    logic [2:0] op_sel;
    logic       op_valid;
    int         loads;
    int         clears;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btnu, btnd, btnr, btnl, btnc} = b;
  endtask

  task automatic apply(input logic [4:0] b, input int hold, input int rel);
    set_btns(b);
    for (int k = 0; k < hold; k++) tick();
    set_btns(5'b0);
    for (int k = 0; k < rel; k++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int l0, c0, lat, drop;

    vecs[0]  = '{5'b00010,  3, 3'b000, 1'b0, 0, 0}; // btnl glitch
    vecs[1]  = '{5'b00010, 10, 3'b010, 1'b1, 0, 0}; // btnl select
    vecs[2]  = '{5'b00100, 10, 3'b100, 1'b1, 0, 0}; // btnr re-latch
    vecs[3]  = '{5'b01000, 10, 3'b100, 1'b0, 1, 0}; // execute
    vecs[4]  = '{5'b01000, 10, 3'b100, 1'b0, 1, 0}; // repeat last op
    vecs[5]  = '{5'b00011, 10, 3'b011, 1'b1, 0, 0}; // l+c together
    vecs[6]  = '{5'b00001,  3, 3'b011, 1'b1, 0, 0}; // btnc glitch
    vecs[7]  = '{5'b01000,  3, 3'b011, 1'b1, 0, 0}; // btnd glitch
    vecs[8]  = '{5'b10000, 10, 3'b000, 1'b0, 0, 1}; // clear
    vecs[9]  = '{5'b01000, 10, 3'b000, 1'b0, 1, 0}; // execute op 000
    vecs[10] = '{5'b00001, 10, 3'b001, 1'b1, 0, 0}; // btnc select
    vecs[11] = '{5'b11000, 10, 3'b000, 1'b0, 0, 1}; // u+d in SELECT
    vecs[12] = '{5'b01001, 10, 3'b000, 1'b0, 1, 0}; // d beats c
    vecs[13] = '{5'b00111, 10, 3'b111, 1'b1, 0, 0}; // r+l+c
    vecs[14] = '{5'b10000, 10, 3'b000, 1'b0, 0, 1}; // clear

    rst_n = 1'b0;
    set_btns(5'b0);
    for (int k = 0; k < 3; k++) tick();
    check("reset outputs", {op_sel, op_valid, acc_load, acc_clear, busy}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("idle outputs", {op_sel, op_valid, acc_load, acc_clear, busy}, 0);

    for (int i = 0; i < 15; i++) begin
      l0 = n_load;
      c0 = n_clear;
      apply(vecs[i].btn, vecs[i].hold, 15);
      check($sformatf("row%0d op_sel", i),   op_sel,   vecs[i].op_sel);
      check($sformatf("row%0d op_valid", i), op_valid, vecs[i].op_valid);
      check($sformatf("row%0d busy", i),     busy,     0);
      check($sformatf("row%0d loads", i),    n_load - l0,  vecs[i].loads);
      check($sformatf("row%0d clears", i),   n_clear - c0, vecs[i].clears);
    end

    // Select latency: op_valid rises on the 8th edge after btnl goes high.
    lat = 0;
    btnl = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (op_valid === 1'b1 && lat == 0) lat = k;
    end
    check("select latency", lat, 8);
    check("latency op_sel", op_sel, 3'b010);
    apply(5'b0, 0, 15);

    // Execute with btnd held 50 cycles, btnc pressed during HOLD.
    apply(5'b00100, 10, 15);
    check("exec pre op_sel", op_sel, 3'b100);
    l0 = n_load;
    c0 = n_clear;
    btnd = 1'b1;
    for (int k = 0; k < 50; k++) begin
      btnc = (k >= 20 && k < 30);
      tick();
    end
    check("hold busy", busy, 1);
    check("hold op_valid", op_valid, 0);
    check("hold op_sel", op_sel, 3'b100);
    check("hold loads", n_load - l0, 1);
    check("hold clears", n_clear - c0, 0);
    drop = 0;
    btnd = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (busy === 1'b0 && drop == 0) drop = k;
    end
    check("busy drop latency", drop, 7);
    check("post hold op_sel", op_sel, 3'b100);
    l0 = n_load;
    apply(5'b01000, 10, 15);
    check("repeat loads", n_load - l0, 1);
    check("repeat op_sel", op_sel, 3'b100);

    // Reset during HOLD with btnd held through release.
    btnd = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {op_sel, op_valid, acc_load, acc_clear, busy}, 0);
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    l0 = n_load;
    for (int k = 0; k < 30; k++) tick();
    check("held btnd after reset loads", n_load - l0, 0);
    check("held btnd after reset busy", busy, 0);
    apply(5'b0, 0, 15);
    check("released btnd loads", n_load - l0, 0);
    apply(5'b01000, 10, 15);
    check("fresh press loads", n_load - l0, 1);

    check("load and clear overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Front-panel sequencer for the calculator datapath (decoder + ALU + accumulator).
- Synchronises and debounces the five raw push-buttons, then latches the operation selection.
- Issues single-cycle accumulator load/clear strobes through a small FSM, so one physical press produces exactly one accumulator update.
- Sits between the board buttons and the accumulator register; the decoder consumes op_sel.

Parameters:
DB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (board build overrides to 1_000_000)
DB_W, 20, width of each debounce counter; must hold DB_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btnc  input  1  raw centre button, asynchronous to clk
btnl  input  1  raw left button, asynchronous to clk
btnr  input  1  raw right button, asynchronous to clk
btnu  input  1  raw up button (clear request), asynchronous to clk
btnd  input  1  raw down button (execute request), asynchronous to clk
op_sel  output  3  latched {btnr,btnl,btnc} selection for the decoder
op_valid  output  1  high while a selection is latched and awaiting execute
acc_load  output  1  one-cycle strobe: accumulator <= ALU result
acc_clear  output  1  one-cycle strobe: accumulator <= 0
busy  output  1  high from the execute strobe until btnd is released

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n). All state changes on rising clk.
- Reset state: FSM in IDLE; op_sel=0, op_valid=0, acc_load=0, acc_clear=0, busy=0; synchronisers, debounced levels and counters all 0.
- Reset asserted mid-operation aborts immediately; no strobe is emitted on or after release.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter resets whenever the synchronised input equals the debounced level; otherwise it increments.
  - When the counter reaches DB_CYCLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DB_CYCLES cycles produces no change.
  - A registered rising-edge detect on the debounced level gives a one-cycle press pulse.
- Latency: raw high held stable → press pulse after 2 + DB_CYCLES + 1 cycles. Strobe outputs are registered, adding 1 more cycle.
- FSM states:
  - IDLE: op-button press → SELECT; btnd press → EXEC, using the current op_sel (repeat-last-op).
  - SELECT: op_valid=1. A further op-button press re-latches op_sel. btnd press → EXEC.
  - EXEC: acc_load=1 and busy=1 for exactly one cycle → HOLD.
  - HOLD: busy=1. Waits for debounced btnd low → IDLE. All op and btnd presses are ignored.
- op_sel latch: on any op-button press pulse, op_sel <= current debounced {btnr,btnl,btnc} levels. Simultaneous presses therefore latch the combined code.
- btnu press, from any state:
  - acc_clear=1 for one cycle, then op_sel <= 0 and FSM → IDLE.
  - Overrides btnd and op presses in the same cycle; no acc_load in that cycle.
  - An EXEC strobe already issued is not retracted.
- Priority in the same cycle: btnu > btnd > op buttons.
- acc_load and acc_clear are never high together.
- busy=1 exactly in EXEC and HOLD.
- op_valid=1 exactly in SELECT.

Decomposition:
- Shared package/header calc_pkg: FSM state encodings (IDLE, SELECT, EXEC, HOLD, 2 bits) and the op_sel bit ordering {R,L,C}. The decoder also uses the bit ordering.
- Sub-module btn_debounce (synchroniser + counter + edge detect, params DB_CYCLES/DB_W; outputs level, press), instantiated five times.
- FSM and output registers live in calc_ctrl.

Test Plan (DB_CYCLES=4):
- Reset: rst_n low mid-HOLD with btnd high → all outputs 0 immediately; after release with btnd still high, no acc_load ever fires until btnd is released and pressed again.
- Debounce: btnl high 3 cycles then low → op_sel stays 000, op_valid 0. btnl held 10 cycles → op_sel=010, op_valid=1, exactly 2+4+1+1=8 cycles after the first sampled high.
- Execute: latch btnr (op_sel=100), then hold btnd 50 cycles → acc_load high exactly 1 cycle, busy high until 4+ cycles after btnd release, op_valid 0 after EXEC; a second btnd press repeats acc_load with op_sel=100.
- Simultaneous selection: btnl and btnc rise together → op_sel=011, single SELECT entry.
- Clear priority: btnu and btnd debounced-rise in the same cycle while in SELECT → acc_clear 1 cycle, no acc_load, op_sel=000, state IDLE.
- Ignore during HOLD: btnc pressed while btnd held → op_sel unchanged, no extra strobes.
